// File: rtl/uart_monitor_ext.sv
`default_nettype none
// ============================================================================
//  Module   : uart_monitor_ext
//  Brief    : Simulation-side UART receive monitor. Decodes frames on a
//             monitored TX line (configurable bit period, data width, parity
//             and stop bits), strobes each good byte / parity error / frame
//             error, and keeps running good-frame and error counters.
//             Optional line logger enabled by macro UART_MON_PRINT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_monitor_ext #(
    parameter int CLKS_PER_BIT = 1798,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int LINE_LEN     = 128
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        parity_err_o,
    output logic        frame_err_o,
    output logic        busy_o,
    output logic [31:0] byte_cnt_o,
    output logic [31:0] err_cnt_o
);

    // Elaboration-time rejection of unsupported configurations
    if (CLKS_PER_BIT < 4) begin : g_chk_cpb
        $error("uart_monitor_ext: CLKS_PER_BIT must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_data
        $error("uart_monitor_ext: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_par
        $error("uart_monitor_ext: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_monitor_ext: STOP_BITS must be 1 or 2");
    end
    if (LINE_LEN < 2) begin : g_chk_line
        $error("uart_monitor_ext: LINE_LEN must be >= 2");
    end

    // First sample lands mid start bit, later samples one full bit apart
    localparam logic [31:0] c_half      = 32'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] c_full      = 32'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  c_last_bit  = 3'(DATA_BITS - 1);
    localparam logic        c_last_stop = 1'(STOP_BITS - 1);
    localparam logic        c_par_odd   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4,
        S_BREAK = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_rx_q;
    logic [31:0]            r_bcnt;
    logic [2:0]             r_bit_idx;
    logic                   r_stop_idx;
    logic                   r_stop_low;
    logic                   r_par_err;
    logic [DATA_BITS-1:0]   r_shift;
    logic [7:0]             r_data;
    logic                   r_valid;
    logic                   r_perr;
    logic                   r_ferr;
    logic [31:0]            r_byte_cnt;
    logic [31:0]            r_err_cnt;

    logic                   w_fall;
    logic                   w_active;
    logic                   w_sample;
    logic                   w_last_data;
    logic                   w_last_stop;
    logic                   w_stop_bad;
    logic                   w_par_bad;
    logic                   w_good;
    logic                   w_perr_set;
    logic                   w_ferr_set;
    logic [7:0]             w_data_ext;

    assign w_fall      = r_rx_q & ~uart_rx_i;
    assign w_active    = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PAR)   || (r_state == S_STOP);
    assign w_sample    = w_active && (r_bcnt == 32'd0);
    assign w_last_data = (r_bit_idx == c_last_bit);
    assign w_last_stop = (r_stop_idx == c_last_stop);
    assign w_stop_bad  = r_stop_low | ~uart_rx_i;
    assign w_par_bad   = ((^r_shift) ^ uart_rx_i) != c_par_odd;

    // Right-align the received word, zero-filling unused upper bits
    always_comb begin
        w_data_ext                = 8'h00;
        w_data_ext[DATA_BITS-1:0] = r_shift;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and frame-outcome decode; frame error beats parity error
    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_perr_set  = 1'b0;
        w_ferr_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_sample) w_state_nxt = uart_rx_i ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_sample && w_last_data)
                    w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                if (w_sample) w_state_nxt = S_STOP;
            end
            S_STOP: begin
                if (w_sample && w_last_stop) begin
                    if (w_stop_bad) begin
                        w_ferr_set  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end else if (r_par_err) begin
                        w_perr_set  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_good      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_BREAK: begin
                if (uart_rx_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit timing, shift register, sticky flags, strobes and counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_q     <= 1'b1;
            r_bcnt     <= 32'd0;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_stop_low <= 1'b0;
            r_par_err  <= 1'b0;
            r_shift    <= '0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_byte_cnt <= 32'd0;
            r_err_cnt  <= 32'd0;
        end else begin
            r_rx_q <= uart_rx_i;
            r_valid <= w_good;
            r_perr  <= w_perr_set;
            r_ferr  <= w_ferr_set;

            if (r_state == S_IDLE && w_fall) begin
                r_bcnt     <= c_half;
                r_bit_idx  <= 3'd0;
                r_stop_idx <= 1'b0;
                r_stop_low <= 1'b0;
                r_par_err  <= 1'b0;
            end else if (w_active) begin
                r_bcnt <= w_sample ? c_full : r_bcnt - 32'd1;
            end

            if (w_sample) begin
                case (r_state)
                    S_DATA: begin
                        r_shift   <= {uart_rx_i, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                    end
                    S_PAR: begin
                        r_par_err <= w_par_bad;
                    end
                    S_STOP: begin
                        r_stop_idx <= r_stop_idx + 1'b1;
                        r_stop_low <= r_stop_low | ~uart_rx_i;
                    end
                    default: ;
                endcase
            end

            if (w_good) begin
                r_data     <= w_data_ext;
                r_byte_cnt <= r_byte_cnt + 32'd1;
            end
            if (w_perr_set || w_ferr_set) begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
        end
    end

    assign data_o       = r_data;
    assign valid_o      = r_valid;
    assign parity_err_o = r_perr;
    assign frame_err_o  = r_ferr;
    assign busy_o       = (r_state != S_IDLE);
    assign byte_cnt_o   = r_byte_cnt;
    assign err_cnt_o    = r_err_cnt;

`ifdef UART_MON_PRINT_EN
    // Text line logger: newest character enters at the low byte so %s
    // prints oldest-first; CR dropped, error frames show as '?'
    logic [8*LINE_LEN-1:0] r_line;
    logic [31:0]           r_line_len;
    logic                  w_push;
    logic                  w_flush_lf;
    logic [7:0]            w_char;
    logic [8*LINE_LEN-1:0] w_line_app;

    // Classify the character produced by the frame that just completed
    always_comb begin
        w_push     = 1'b0;
        w_flush_lf = 1'b0;
        w_char     = 8'h00;
        if (w_good) begin
            if (w_data_ext == 8'h0A) begin
                w_flush_lf = 1'b1;
            end else if (w_data_ext != 8'h0D) begin
                w_push = 1'b1;
                w_char = w_data_ext;
            end
        end else if (w_perr_set || w_ferr_set) begin
            w_push = 1'b1;
            w_char = 8'h3F;
        end
        w_line_app = {r_line[8*LINE_LEN-9:0], w_char};
    end

    // Accumulate characters and emit the line on LF or when full
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_line     <= '0;
            r_line_len <= 32'd0;
        end else if (w_flush_lf) begin
            $display("[uart_monitor_ext %m] %s", r_line);
            r_line     <= '0;
            r_line_len <= 32'd0;
        end else if (w_push) begin
            if (r_line_len + 32'd1 == 32'(LINE_LEN)) begin
                $display("[uart_monitor_ext %m] %s", w_line_app);
                r_line     <= '0;
                r_line_len <= 32'd0;
            end else begin
                r_line     <= w_line_app;
                r_line_len <= r_line_len + 32'd1;
            end
        end
    end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_monitor_ext.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_monitor_ext
//  Brief    : Directed self-checking bench for uart_monitor_ext. Four
//             monitors share clock/reset: 8N1, 8E1, 8N2 and 7O1, all at 16
//             clocks per bit, each with its own serial line.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_monitor_ext;

    localparam int c_cpb = 16;

    logic        clk;
    logic        rst;
    logic [3:0]  rx;
    logic [7:0]  data  [4];
    logic [3:0]  valid;
    logic [3:0]  perr;
    logic [3:0]  ferr;
    logic [3:0]  busy;
    logic [31:0] bcnt  [4];
    logic [31:0] ecnt  [4];

    int total = 0;
    int bad   = 0;
    int n_valid [4] = '{0, 0, 0, 0};
    int n_perr  [4] = '{0, 0, 0, 0};
    int n_ferr  [4] = '{0, 0, 0, 0};

    uart_monitor_ext #(.CLKS_PER_BIT(c_cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .LINE_LEN(16)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(rx[0]), .data_o(data[0]), .valid_o(valid[0]),
        .parity_err_o(perr[0]), .frame_err_o(ferr[0]), .busy_o(busy[0]),
        .byte_cnt_o(bcnt[0]), .err_cnt_o(ecnt[0]));

    uart_monitor_ext #(.CLKS_PER_BIT(c_cpb), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .LINE_LEN(16)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(rx[1]), .data_o(data[1]), .valid_o(valid[1]),
        .parity_err_o(perr[1]), .frame_err_o(ferr[1]), .busy_o(busy[1]),
        .byte_cnt_o(bcnt[1]), .err_cnt_o(ecnt[1]));

    uart_monitor_ext #(.CLKS_PER_BIT(c_cpb), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .LINE_LEN(16)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(rx[2]), .data_o(data[2]), .valid_o(valid[2]),
        .parity_err_o(perr[2]), .frame_err_o(ferr[2]), .busy_o(busy[2]),
        .byte_cnt_o(bcnt[2]), .err_cnt_o(ecnt[2]));

    uart_monitor_ext #(.CLKS_PER_BIT(c_cpb), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .LINE_LEN(16)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .uart_rx_i(rx[3]), .data_o(data[3]), .valid_o(valid[3]),
        .parity_err_o(perr[3]), .frame_err_o(ferr[3]), .busy_o(busy[3]),
        .byte_cnt_o(bcnt[3]), .err_cnt_o(ecnt[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe-high cycles so a stretched strobe shows up as extra pulses
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (valid[i]) n_valid[i]++;
            if (perr[i])  n_perr[i]++;
            if (ferr[i])  n_ferr[i]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold one line level for n clock edges; returns just after an edge
    task automatic drive_bit(input int sel, input logic b, input int n);
        rx[sel] = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_head(input int sel, input logic [7:0] d, input int nbits,
                             input int has_par, input logic pbit);
        drive_bit(sel, 1'b0, c_cpb);
        for (int i = 0; i < nbits; i++) drive_bit(sel, d[i], c_cpb);
        if (has_par != 0) drive_bit(sel, pbit, c_cpb);
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input int nbits,
                              input int has_par, input logic pbit, input int nstop);
        send_head(sel, d, nbits, has_par, pbit);
        for (int i = 0; i < nstop; i++) drive_bit(sel, 1'b1, c_cpb);
        drive_bit(sel, 1'b1, 8);
    endtask

    initial begin
        rx  = 4'hF;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_data%0d", i), 32'(data[i]), 32'h0);
            check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'h0);
            check($sformatf("rst_bcnt%0d", i), bcnt[i], 32'h0);
            check($sformatf("rst_ecnt%0d", i), ecnt[i], 32'h0);
        end
        check("rst_strobes", 32'({valid, perr, ferr}), 32'h0);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // 8N1: single good byte
        send_frame(0, 8'h41, 8, 0, 1'b0, 1);
        check("n1_valid_pulses", 32'(n_valid[0]), 32'd1);
        check("n1_data", 32'(data[0]), 32'h41);
        check("n1_bcnt", bcnt[0], 32'd1);
        check("n1_ecnt", ecnt[0], 32'd0);
        check("n1_busy", 32'(busy[0]), 32'd0);

        // 8N1: stop bit cut to C/2+1 clocks so the next start edge lands
        // in the very cycle the monitor returns to idle
        send_head(0, 8'hA5, 8, 0, 1'b0);
        drive_bit(0, 1'b1, c_cpb / 2 + 1);
        send_frame(0, 8'h3C, 8, 0, 1'b0, 1);
        check("b2b_valid_pulses", 32'(n_valid[0]), 32'd3);
        check("b2b_data", 32'(data[0]), 32'h3C);
        check("b2b_bcnt", bcnt[0], 32'd3);
        check("b2b_ferr", 32'(n_ferr[0]), 32'd0);

        // 8N1: 5-clock low glitch is rejected at the start-bit sample
        drive_bit(0, 1'b0, 5);
        @(negedge clk);
        check("glitch_busy_hi", 32'(busy[0]), 32'd1);
        drive_bit(0, 1'b1, 6);
        @(negedge clk);
        check("glitch_busy_lo", 32'(busy[0]), 32'd0);
        check("glitch_valid", 32'(n_valid[0]), 32'd3);
        check("glitch_cnts", {bcnt[0][15:0], ecnt[0][15:0]}, {16'd3, 16'd0});
        check("glitch_err_strobes", 32'(n_perr[0] + n_ferr[0]), 32'd0);

        // 8E1: 0x41 has two ones, parity bit 1 is wrong
        send_frame(1, 8'h41, 8, 1, 1'b1, 1);
        check("even_perr_pulses", 32'(n_perr[1]), 32'd1);
        check("even_bad_valid", 32'(n_valid[1]), 32'd0);
        check("even_bad_ecnt", ecnt[1], 32'd1);
        check("even_bad_data", 32'(data[1]), 32'h00);
        // 8E1: 0x80 has one one, parity bit 1 is right
        send_frame(1, 8'h80, 8, 1, 1'b1, 1);
        check("even_good_valid", 32'(n_valid[1]), 32'd1);
        check("even_good_data", 32'(data[1]), 32'h80);
        check("even_good_bcnt", bcnt[1], 32'd1);
        check("even_good_perr", 32'(n_perr[1]), 32'd1);
        // 8E1: bad parity plus low stop bit reports only a frame error
        send_head(1, 8'h41, 8, 1, 1'b1);
        drive_bit(1, 1'b0, c_cpb);
        drive_bit(1, 1'b1, 8);
        check("prec_ferr", 32'(n_ferr[1]), 32'd1);
        check("prec_perr", 32'(n_perr[1]), 32'd1);
        check("prec_ecnt", ecnt[1], 32'd2);

        // 7O1: 0x53 (4 ones in 7 bits) needs parity 1; then parity 0 is wrong
        send_frame(3, 8'h53, 7, 1, 1'b1, 1);
        check("odd7_valid", 32'(n_valid[3]), 32'd1);
        check("odd7_data", 32'(data[3]), 32'h53);
        send_frame(3, 8'h53, 7, 1, 1'b0, 1);
        check("odd7_perr", 32'(n_perr[3]), 32'd1);
        check("odd7_cnts", {bcnt[3][15:0], ecnt[3][15:0]}, {16'd1, 16'd1});

        // 8N2: second stop low, line held low 40 more clocks
        send_head(2, 8'h55, 8, 0, 1'b0);
        drive_bit(2, 1'b1, c_cpb);
        drive_bit(2, 1'b0, c_cpb + 40);
        @(negedge clk);
        check("n2_ferr_pulses", 32'(n_ferr[2]), 32'd1);
        check("n2_ecnt", ecnt[2], 32'd1);
        check("n2_break_busy", 32'(busy[2]), 32'd1);
        check("n2_no_valid", 32'(n_valid[2] + n_perr[2]), 32'd0);
        drive_bit(2, 1'b1, 4);
        @(negedge clk);
        check("n2_idle_busy", 32'(busy[2]), 32'd0);
        send_frame(2, 8'h33, 8, 0, 1'b0, 2);
        check("n2_valid", 32'(n_valid[2]), 32'd1);
        check("n2_data", 32'(data[2]), 32'h33);
        check("n2_bcnt", bcnt[2], 32'd1);

        // 8N1: reset while bit 3 of 0xF8 is on the line
        drive_bit(0, 1'b0, c_cpb);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b0, c_cpb);
        drive_bit(0, 1'b1, 5);
        check("mid_busy_before", 32'(busy[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_busy", 32'(busy[0]), 32'd0);
        check("mid_data", 32'(data[0]), 32'h00);
        check("mid_bcnt", bcnt[0], 32'd0);
        check("mid_ecnt1", ecnt[1], 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_bit(0, 1'b1, 9);
        for (int i = 4; i < 8; i++) drive_bit(0, 1'b1, c_cpb);
        drive_bit(0, 1'b1, c_cpb + 8);
        check("mid_no_strobe", 32'(n_valid[0] + n_perr[0] + n_ferr[0]), 32'd3);
        check("mid_bcnt_after", bcnt[0], 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_monitor_ext.md
Name: uart_monitor_ext

Overview:
Parametrised, simulation-side UART receive monitor for the testbench. It watches a DUT UART TX line and decodes frames with configurable bit period, data width, parity and stop bits. It reports each byte, parity and framing errors on strobes, and keeps running counters. It sits in tb/modules beside the SoC and is instantiated once per monitored UART.

Parameters:
CLKS_PER_BIT, 1798, clk_i cycles per UART bit; legal range >= 4
DATA_BITS, 8, data bits per frame; legal range 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
LINE_LEN, 128, character capacity of the line buffer (optional feature only)

Ports:
clk_i  in  1  monitor clock; the same clock that drives the DUT UART
rst_i  in  1  reset, asynchronous, active-high
uart_rx_i  in  1  monitored serial line; idles high
data_o  out  8  last received byte, right-aligned, upper bits zero when DATA_BITS < 8
valid_o  out  1  one-cycle strobe: data_o updated with a good frame
parity_err_o  out  1  one-cycle strobe: parity mismatch
frame_err_o  out  1  one-cycle strobe: a stop bit was sampled low
busy_o  out  1  high while a frame is in progress (all states except IDLE)
byte_cnt_o  out  32  count of good frames
err_cnt_o  out  32  count of parity and frame errors combined

Behaviour:
- Reset: rx_q=1, state=IDLE, data_o=0, valid_o=0, parity_err_o=0, frame_err_o=0, busy_o=0, both counters=0. Reset mid-frame aborts the frame with no strobe.
- rx_q is a one-flop registered copy of uart_rx_i. A falling edge is rx_q=1 and uart_rx_i=0.
- Bit counter bcnt, 32 bit. On the falling edge it loads CLKS_PER_BIT/2 - 1. After each sample it reloads CLKS_PER_BIT - 1. It decrements every cycle, and a sample is taken in the cycle bcnt==0.
- IDLE: on falling edge go to START and load bcnt.
- START: at the sample, if uart_rx_i=1 treat it as a glitch: go to IDLE with no strobe and no count change. Otherwise go to DATA with bit index 0.
- DATA: sample data LSB first into a shift register. After the DATA_BITS-th sample go to PAR if PARITY!=0, else to STOP.
- PAR: sample the parity bit.
  - Even: data XOR parity bit must be 0.
  - Odd: data XOR parity bit must be 1.
  - Record a mismatch in a sticky flag, then go to STOP.
- STOP: sample STOP_BITS stop bits.
  - Any stop bit low: pulse frame_err_o on the final sample, increment err_cnt_o by 1, go to BREAK.
  - All high and parity flag set: pulse parity_err_o, increment err_cnt_o, go to IDLE.
  - All high and no parity error: update data_o, pulse valid_o, increment byte_cnt_o, go to IDLE.
- A frame error takes precedence over a parity error: only frame_err_o pulses.
- BREAK: wait until uart_rx_i=1, then go to IDLE. A low line never starts a new frame.
- Strobes are registered, asserted exactly one cycle, and occur in the cycle after the final sample.
- Counters wrap from 0xFFFFFFFF to 0.
- A falling edge in the same cycle as the IDLE return is not missed: it starts the next frame.

Optional Feature:
Macro UART_MON_PRINT_EN.
- When defined: each good byte is appended to a LINE_LEN-entry buffer.
  - On 0x0A, or when the buffer is full, the module issues $display("[uart_monitor_ext %m] %s", line) and clears the buffer.
  - 0x0D is discarded.
  - Error frames append "?".
- When undefined: no buffer, no system tasks. Port behaviour is identical in both cases.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0x41 → valid_o pulses once, data_o=0x41, byte_cnt_o=1, err_cnt_o=0.
- PARITY=2, send 0x41 with parity bit 1 → parity_err_o pulses once, valid_o stays 0, err_cnt_o=1, data_o unchanged.
- Low glitch of 5 clocks on the idle line → no strobes, busy_o returns to 0 by cycle 8, counters unchanged.
- STOP_BITS=2, send 0x55 with the second stop bit low and the line held low for 40 clocks → frame_err_o pulses once, busy_o stays high until the line rises, then 0x33 is received correctly.
- Assert rst_i during bit 3 of a frame → all outputs return to reset values immediately, and the remainder of the frame produces no strobe.
- With UART_MON_PRINT_EN defined, send "Hi\r\n" → exactly one log line containing "Hi", and byte_cnt_o=4.
